// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler: default build parameters,
// channel-index width helper and the per-channel write command.
package tick_sched_pkg;

   localparam int unsigned PRESCALE_DEF = 250000;
   localparam int unsigned NCH_DEF      = 4;
   localparam int unsigned PERIOD_W_DEF = 8;

   // Channel select width; a single channel still gets a 1-bit select.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Default-build views; parameterised modules derive their own widths.
   typedef logic [ch_w(NCH_DEF)-1:0] ch_t;
   typedef logic [PERIOD_W_DEF-1:0]  period_t;

   typedef struct packed {
      logic    en;
      logic    pend;
      period_t period;
      period_t pend_period;
      period_t cnt;
   } chan_state_t;

   // Decoded config write as seen by one channel.
   typedef enum logic [1:0] {
      CmdNone,
      CmdProg,
      CmdOff
   } cmd_e;

endpackage

// File: rtl/tick_sched_if.sv
// Config write port: valid/ready handshake carrying channel, enable and period.
interface tick_sched_if
   import tick_sched_pkg::*;
#(
   parameter int unsigned NCH      = NCH_DEF,
   parameter int unsigned PERIOD_W = PERIOD_W_DEF
) ();

   localparam int unsigned CFG_CH_W = ch_w(NCH);

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CFG_CH_W-1:0] cfg_ch;
   logic                cfg_en;
   logic [PERIOD_W-1:0] cfg_period;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_en,
      output cfg_period,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_en,
      input  cfg_period,
      output cfg_ready
   );

endinterface

// File: rtl/tick_chan.sv
// One scheduler channel: down-counts base strobes, reloads on expiry and
// registers a single-cycle enable strobe. Reprogramming an active channel
// is deferred to its next expiry so the running period is never cut short.
module tick_chan
   import tick_sched_pkg::*;
#(
   parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
   input  logic                fastClk,
   input  logic                rstn,
   input  logic                i_tick,
   input  cmd_e                i_cmd,
   input  logic [PERIOD_W-1:0] i_period,
   output logic                o_pend,
   output logic                o_strobe
);

   typedef struct packed {
      logic                en;
      logic                pend;
      logic [PERIOD_W-1:0] period;
      logic [PERIOD_W-1:0] pend_period;
      logic [PERIOD_W-1:0] cnt;
   } state_t;

   state_t r_st;
   logic   r_strobe;
   logic   w_expire;

   assign w_expire = i_tick & r_st.en & (r_st.cnt == '0);

   // Channel state update: disable wins, then expiry reload, then plain write/count.
   always_ff @(posedge fastClk) begin
      if (!rstn) begin
         r_st     <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= w_expire & (i_cmd != CmdOff);
         if (i_cmd == CmdOff) begin
            r_st.en   <= 1'b0;
            r_st.pend <= 1'b0;
            r_st.cnt  <= '0;
         end else if (w_expire) begin
            r_st.pend <= 1'b0;
            if (i_cmd == CmdProg) begin
               // Same-cycle write takes effect for this very reload.
               r_st.period <= i_period;
               r_st.cnt    <= i_period - 1'b1;
            end else if (r_st.pend) begin
               r_st.period <= r_st.pend_period;
               r_st.cnt    <= r_st.pend_period - 1'b1;
            end else begin
               r_st.cnt <= r_st.period - 1'b1;
            end
         end else begin
            if (i_cmd == CmdProg) begin
               if (r_st.en) begin
                  r_st.pend        <= 1'b1;
                  r_st.pend_period <= i_period;
               end else begin
                  r_st.en     <= 1'b1;
                  r_st.period <= i_period;
                  r_st.cnt    <= i_period - 1'b1;
               end
            end
            if (i_tick && r_st.en) begin
               r_st.cnt <= r_st.cnt - 1'b1;
            end
         end
      end
   end

   assign o_pend   = r_st.pend;
   assign o_strobe = r_strobe;

endmodule

// File: rtl/tick_sched.sv
// Shared-prescaler tick scheduler: one fastClk prescaler produces a base
// strobe that drives NCH independently programmable channel counters.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEF,
   parameter int unsigned NCH      = NCH_DEF,
   parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
   input  logic           fastClk,
   input  logic           rstn,
   input  logic           i_run,
   tick_sched_if.slave    io_cfg,
   output logic           o_base_tick,
   output logic [NCH-1:0] o_tick_out
);

   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_pre;
   logic             r_base_tick;
   logic             w_wrap;
   logic [NCH-1:0]   w_pend;
   logic             w_ch_ok;
   logic             w_dis;
   logic             w_accept;

   assign w_wrap = i_run & (r_pre == PRE_LAST);

   // Prescaler: counts only while running, holds its phase while frozen.
   always_ff @(posedge fastClk) begin
      if (!rstn) begin
         r_pre       <= '0;
         r_base_tick <= 1'b0;
      end else begin
         r_base_tick <= w_wrap;
         if (w_wrap) begin
            r_pre <= '0;
         end else if (i_run) begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   assign w_ch_ok  = 32'(io_cfg.cfg_ch) < NCH;
   assign w_dis    = ~io_cfg.cfg_en | (io_cfg.cfg_period == '0);
   // Disables bypass ready; out-of-range channels are accepted and dropped.
   assign w_accept = io_cfg.cfg_valid & (io_cfg.cfg_ready | w_dis) & w_ch_ok;

   // Ready mux: busy only while the addressed channel holds a deferred write.
   always_comb begin
      io_cfg.cfg_ready = 1'b1;
      if (w_ch_ok) begin
         io_cfg.cfg_ready = ~w_pend[io_cfg.cfg_ch];
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      cmd_e w_cmd;

      // Per-channel decode of an accepted write.
      always_comb begin
         w_cmd = CmdNone;
         if (w_accept && (32'(io_cfg.cfg_ch) == g)) begin
            w_cmd = w_dis ? CmdOff : CmdProg;
         end
      end

      tick_chan #(
         .PERIOD_W (PERIOD_W)
      ) u_chan (
         .fastClk  (fastClk),
         .rstn     (rstn),
         .i_tick   (w_wrap),
         .i_cmd    (w_cmd),
         .i_period (io_cfg.cfg_period),
         .o_pend   (w_pend[g]),
         .o_strobe (o_tick_out[g])
      );
   end

   assign o_base_tick = r_base_tick;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: a "ticks remaining" behavioural model is stepped on
// every clock and compared against the DUT each negedge; directed scenarios
// add literal expectations, then randomized traffic exercises the rest.
module tb_tick_sched;

   localparam int unsigned PRESCALE = 4;
   localparam int unsigned NCH      = 2;
   localparam int unsigned PERIOD_W = 4;

   logic           fastClk = 1'b0;
   logic           rstn    = 1'b0;
   logic           run     = 1'b0;
   logic           base_tick;
   logic [NCH-1:0] tick_out;

   tick_sched_if #(.NCH(NCH), .PERIOD_W(PERIOD_W)) u_if ();

   tick_sched #(
      .PRESCALE (PRESCALE),
      .NCH      (NCH),
      .PERIOD_W (PERIOD_W)
   ) u_dut (
      .fastClk     (fastClk),
      .rstn        (rstn),
      .i_run       (run),
      .io_cfg      (u_if),
      .o_base_tick (base_tick),
      .o_tick_out  (tick_out)
   );

   always #5 fastClk = ~fastClk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   // Model: rem = base ticks still to wait, strobe when a tick arrives at rem==1.
   int m_pre;
   bit m_base;
   bit m_tick [NCH];
   bit m_en   [NCH];
   bit m_pend [NCH];
   int m_per  [NCH];
   int m_rem  [NCH];
   int m_pp   [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_ready();
      int ch;
      ch = int'(u_if.cfg_ch);
      return (ch >= NCH) ? 1'b1 : !m_pend[ch];
   endfunction

   function automatic logic [NCH-1:0] m_tick_vec();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = m_tick[c];
      return v;
   endfunction

   task automatic model_step();
      bit wrap, acc, dis, due;
      int ch, p, np;
      if (!rstn) begin
         m_pre  = 0;
         m_base = 0;
         for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 0; m_en[c] = 0; m_pend[c] = 0;
            m_per[c] = 0;  m_rem[c] = 0; m_pp[c] = 0;
         end
         return;
      end
      wrap = run && (m_pre == PRESCALE - 1);
      ch   = int'(u_if.cfg_ch);
      p    = int'(u_if.cfg_period);
      dis  = !u_if.cfg_en || (p == 0);
      for (int c = 0; c < NCH; c++) begin
         acc = u_if.cfg_valid && (ch == c) && (dis || !m_pend[c]);
         due = wrap && m_en[c] && (m_rem[c] == 1);
         m_tick[c] = 0;
         if (acc && dis) begin
            m_en[c] = 0; m_pend[c] = 0; m_rem[c] = 0;
            continue;
         end
         m_tick[c] = due;
         if (wrap && m_en[c]) m_rem[c]--;
         if (due) begin
            np = acc ? p : (m_pend[c] ? m_pp[c] : m_per[c]);
            m_per[c]  = np;
            m_rem[c]  = np;
            m_pend[c] = 0;
         end else if (acc) begin
            if (!m_en[c]) begin
               m_en[c] = 1; m_per[c] = p; m_rem[c] = p;
            end else begin
               m_pend[c] = 1; m_pp[c] = p;
            end
         end
      end
      m_base = wrap;
      m_pre  = wrap ? 0 : (run ? m_pre + 1 : m_pre);
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge fastClk) begin
      if (chk_on) begin
         chk("base_tick", 32'(base_tick), 32'(m_base));
         chk("tick_out", 32'(tick_out), 32'(m_tick_vec()));
         chk("cfg_ready", 32'(u_if.cfg_ready), 32'(m_ready()));
      end
   end

   task automatic step();
      @(posedge fastClk);
      model_step();
      #1;
   endtask

   task automatic drive(input bit v, input int ch, input bit en, input int per);
      u_if.cfg_valid  = v;
      u_if.cfg_ch     = ch[0:0];
      u_if.cfg_en     = en;
      u_if.cfg_period = per[PERIOD_W-1:0];
   endtask

   task automatic idle();
      u_if.cfg_valid = 1'b0;
   endtask

   initial begin
      int  cnt0;
      bit  found;
      drive(0, 0, 0, 0);
      rstn = 1'b0;
      run  = 1'b0;
      repeat (3) step();
      chk_on = 1'b1;
      chk("rst_base", 32'(base_tick), 32'd0);
      chk("rst_tick", 32'(tick_out), 32'd0);
      chk("rst_ready", 32'(u_if.cfg_ready), 32'd1);

      // Released but frozen: nothing may strobe.
      rstn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("frozen_idle", {30'd0, base_tick, |tick_out}, 32'd0);
      end

      // ch0 period 3, then deferred rewrite to period 1 at cycle 12.
      for (int k = 0; k < 32; k++) begin
         if (k == 0)       drive(1, 0, 1, 3);
         else if (k == 12) drive(1, 0, 1, 1);
         else              idle();
         run = 1'b1;
         step();
         chk("a_base", 32'(base_tick), 32'((k % 4) == 3));
         chk("a_tick0", 32'(tick_out[0]), 32'((k == 11) || (k == 23) || (k == 27) || (k == 31)));
         chk("a_tick1", 32'(tick_out[1]), 32'd0);
         chk("a_ready", 32'(u_if.cfg_ready), 32'(!((k >= 12) && (k < 23))));
      end
      idle();

      // Freeze at prescaler count 2 for 10 cycles.
      repeat (2) step();
      run = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("b_frozen", {30'd0, base_tick, |tick_out}, 32'd0);
      end
      run = 1'b1;
      step();
      chk("b_resume1", 32'(base_tick), 32'd0);
      step();
      chk("b_resume2", 32'(base_tick), 32'd1);

      // ch1 period 2, disabled exactly in its expiry cycle.
      drive(1, 1, 1, 2);
      step();
      idle();
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (run && (m_pre == PRESCALE - 1) && m_en[1] && (m_rem[1] == 1)) begin
            drive(1, 1, 0, 2);
            found = 1'b1;
         end
         step();
         idle();
      end
      chk("c_found", 32'(found), 32'd1);
      chk("c_suppressed", 32'(tick_out[1]), 32'd0);
      cnt0 = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("c_tick1_off", 32'(tick_out[1]), 32'd0);
         if (tick_out[0]) cnt0++;
      end
      chk("c_ch0_count", 32'(cnt0), 32'd5);

      // Pending write on ch0, then a one-cycle reset.
      while (m_pre == PRESCALE - 1) step();
      drive(1, 0, 1, 5);
      step();
      idle();
      chk("d_pend_ready", 32'(u_if.cfg_ready), 32'd0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("d_rst_ready", 32'(u_if.cfg_ready), 32'd1);
      for (int k = 0; k < 30; k++) begin
         step();
         chk("d_no_tick", 32'(tick_out), 32'd0);
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         run  = ($urandom_range(0, 9) != 0);
         rstn = ($urandom_range(0, 299) != 0);
         drive($urandom_range(0, 9) < 4, $urandom_range(0, NCH - 1), $urandom_range(0, 9) != 0,
               ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(0, 15));
         step();
      end
      idle();
      rstn = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
